// File: rtl/ddfs_pkg.sv
// Shared types and defaults for the multi-channel DDFS ROM scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddfs_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_PHASE_WIDTH = 30;
    localparam int DEF_ADDR_WIDTH  = 11;
    localparam int DEF_DATA_WIDTH  = 16;

    // Unity gain in unsigned Q1.15.
    localparam logic [15:0] AMP_ONE = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } ddfs_state_t;

    // Index width that stays legal for a single channel.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddfs_rom_scheduler_if.sv
// Read port of the shared single-port sine ROM.
// Latency: ROM returns data one cycle after the address.
// Backpressure: none; the ROM accepts an address every cycle.
interface ddfs_rom_scheduler_if
    import ddfs_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/ddfs_phase_acc.sv
// One channel's phase accumulator: adds fccw on load, or clears when the channel is disabled.
// Latency: new phase visible the cycle after load_i.
// Backpressure: none; load_i is a single-cycle strobe.
module ddfs_phase_acc
    import ddfs_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   en_i,
    input  logic [PHASE_WIDTH-1:0] fccw_i,
    output logic [PHASE_WIDTH-1:0] acc_o
);

    logic [PHASE_WIDTH-1:0] acc_q;
    logic [PHASE_WIDTH-1:0] acc_d;

    // Next phase: modulo add when enabled, restart from zero when disabled.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = en_i ? (acc_q + fccw_i) : '0;
        end
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ddfs_rom_scheduler.sv
// Time-shares one sine ROM across NUM_CH DDFS channels; optional gain stage under DDFS_AMP_SCALE_EN.
// Latency: channel k valid at tick+k+3 (tick+k+4 with gain stage); frame_done with the last channel.
// Backpressure: none; ticks arriving while busy are dropped and flagged in sticky overrun.
module ddfs_rom_scheduler
    import ddfs_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   tick,
    input  logic [NUM_CH-1:0]                      en,
    input  logic [NUM_CH-1:0][PHASE_WIDTH-1:0]     fccw,
    input  logic [NUM_CH-1:0][PHASE_WIDTH-1:0]     pha,
`ifdef DDFS_AMP_SCALE_EN
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]      amp,
`endif
    ddfs_rom_scheduler_if.master                   rom,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0]      ch_data,
    output logic [NUM_CH-1:0]                      ch_valid,
    output logic                                   frame_done,
    output logic                                   busy,
    output logic                                   overrun
);

    localparam int IDX_W = idx_width(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
`ifdef DDFS_AMP_SCALE_EN
    localparam logic [0:0] DRAIN_LAST = 1'b1;   // two drain cycles cover the gain stage
`else
    localparam logic [0:0] DRAIN_LAST = 1'b0;
`endif

    ddfs_state_t                          state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [0:0]                           drain_q, drain_d;
    logic                                 accept;
    logic                                 overrun_q;
    logic [NUM_CH-1:0]                    en_q;
    logic [NUM_CH-1:0][PHASE_WIDTH-1:0]   acc_w;
    logic [PHASE_WIDTH-1:0]               addr_sum;

    logic                                 iss_vld_q;
    logic [IDX_W-1:0]                     iss_idx_q;
    logic                                 out_vld;
    logic [IDX_W-1:0]                     out_idx;
    logic [DATA_WIDTH-1:0]                out_dat;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_data_q;
    logic [NUM_CH-1:0]                    ch_valid_q;
    logic                                 frame_done_q;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_acc
            ddfs_phase_acc #(.PHASE_WIDTH(PHASE_WIDTH)) u_acc (
                .clk    (clk),
                .reset  (reset),
                .load_i (accept),
                .en_i   (en[g]),
                .fccw_i (fccw[g]),
                .acc_o  (acc_w[g])
            );
        end
    endgenerate

    // FSM state, issue index and drain counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    // Frame sequencing: accept tick in IDLE, walk channels in ISSUE, let the pipe empty in DRAIN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (idx_q == LAST_IDX) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = IDLE;
                else                       drain_d = drain_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // ROM address: top bits of the offset phase for the channel being issued, zero otherwise.
    always_comb begin
        addr_sum     = acc_w[idx_q] + pha[idx_q];
        rom.rom_addr = '0;
        if (state_q == ISSUE) rom.rom_addr = addr_sum[PHASE_WIDTH-1 -: ADDR_WIDTH];
    end

    // Sticky overrun: any tick landing outside IDLE is dropped.
    always_ff @(posedge clk) begin
        if (reset)                          overrun_q <= 1'b0;
        else if (tick && state_q != IDLE)   overrun_q <= 1'b1;
    end

    // Per-frame channel enables, frozen at the accepted tick.
    always_ff @(posedge clk) begin
        if (reset)       en_q <= '0;
        else if (accept) en_q <= en;
    end

    // Tag the ROM read in flight so its data can be steered one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_vld_q <= 1'b0;
            iss_idx_q <= '0;
        end else begin
            iss_vld_q <= (state_q == ISSUE);
            iss_idx_q <= idx_q;
        end
    end

`ifdef DDFS_AMP_SCALE_EN
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    amp_q;
    logic signed [2*DATA_WIDTH:0]         prod_q;
    logic signed [2*DATA_WIDTH:0]         prod_shr;
    logic                                 s1_vld_q;
    logic [IDX_W-1:0]                     s1_idx_q;
    localparam logic signed [2*DATA_WIDTH:0] SAT_MAX = {{(DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [2*DATA_WIDTH:0] SAT_MIN = {{(DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Per-frame gains, frozen at the accepted tick.
    always_ff @(posedge clk) begin
        if (reset)       amp_q <= '0;
        else if (accept) amp_q <= amp;
    end

    // Gain multiply: signed sample times unsigned Q1.(DATA_WIDTH-1) gain.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            prod_q   <= '0;
        end else begin
            s1_vld_q <= iss_vld_q;
            s1_idx_q <= iss_idx_q;
            if (iss_vld_q) begin
                prod_q <= en_q[iss_idx_q]
                        ? $signed(rom.rom_data) * $signed({1'b0, amp_q[iss_idx_q]})
                        : '0;
            end
        end
    end

    // Rescale and saturate the product back to sample width.
    always_comb begin
        prod_shr = prod_q >>> (DATA_WIDTH - 1);
        out_vld  = s1_vld_q;
        out_idx  = s1_idx_q;
        out_dat  = prod_shr[DATA_WIDTH-1:0];
        if (prod_shr > SAT_MAX)      out_dat = SAT_MAX[DATA_WIDTH-1:0];
        else if (prod_shr < SAT_MIN) out_dat = SAT_MIN[DATA_WIDTH-1:0];
    end
`else
    // Raw ROM data, forced to zero for disabled channels.
    always_comb begin
        out_vld = iss_vld_q;
        out_idx = iss_idx_q;
        out_dat = en_q[iss_idx_q] ? rom.rom_data : '0;
    end
`endif

    // Output registers: update one channel per cycle and pulse its valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            if (out_vld) begin
                ch_data_q[out_idx]  <= out_dat;
                ch_valid_q[out_idx] <= 1'b1;
                frame_done_q        <= (out_idx == LAST_IDX);
            end
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ddfs_rom_scheduler.sv
// Directed bench for ddfs_rom_scheduler with a 2048-entry sine ROM model.
// Latency: checks cycle-exact issue/valid/frame_done timing per frame.
// Backpressure: covers dropped ticks, overrun and back-to-back frames.
module tb_ddfs_rom_scheduler;
    import ddfs_pkg::*;

`ifdef DDFS_AMP_SCALE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              tick;
    logic [3:0]        en;
    logic [3:0][29:0]  fccw;
    logic [3:0][29:0]  pha;
    logic [3:0][15:0]  amp;
    logic [3:0][15:0]  ch_data;
    logic [3:0]        ch_valid;
    logic              frame_done;
    logic              busy;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] mem [0:2047];

    ddfs_rom_scheduler_if #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) rom_if ();

    ddfs_rom_scheduler #(
        .NUM_CH(4), .PHASE_WIDTH(30), .ADDR_WIDTH(11), .DATA_WIDTH(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .en         (en),
        .fccw       (fccw),
        .pha        (pha),
`ifdef DDFS_AMP_SCALE_EN
        .amp        (amp),
`endif
        .rom        (rom_if),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // One-cycle registered sine ROM.
    always @(posedge clk) rom_if.rom_data <= mem[rom_if.rom_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick  = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    function automatic logic [15:0] expd(input logic [10:0] a, input logic e);
        return e ? mem[a] : 16'h0000;
    endfunction

    // Tick now (an idle cycle T) and check every cycle up to the next idle cycle.
    task automatic frame(input string tag, input logic [3:0][10:0] ea);
        int k;
        chk($sformatf("%s_idle_busy", tag), busy, 0);
        chk($sformatf("%s_idle_addr", tag), rom_if.rom_addr, 0);
        tick = 1'b1;
        for (int c = 1; c <= 6 + PIPE; c++) begin
            cyc();
            if (c == 1) tick = 1'b0;
            chk($sformatf("%s_busy_c%0d", tag, c), busy, (c <= 5 + PIPE));
            if (c <= 4) chk($sformatf("%s_addr_c%0d", tag, c), rom_if.rom_addr, ea[c-1]);
            else        chk($sformatf("%s_addr_c%0d", tag, c), rom_if.rom_addr, 0);
            chk($sformatf("%s_done_c%0d", tag, c), frame_done, (c == 6 + PIPE));
            if (c >= 3 + PIPE) begin
                k = c - 3 - PIPE;
                chk($sformatf("%s_vld_c%0d", tag, c), ch_valid, 4'b0001 << k);
                chk($sformatf("%s_dat%0d", tag, k), ch_data[k], expd(ea[k], en[k]));
            end else begin
                chk($sformatf("%s_vld_c%0d", tag, c), ch_valid, 0);
            end
        end
    endtask

    initial begin
        int fd;
        real ph;
        for (int i = 0; i < 2048; i++) begin
            ph = 2.0 * 3.14159265358979 * i / 2048.0;
            mem[i] = 16'($rtoi($floor(32767.0 * $sin(ph) + 0.5)));
        end
        reset = 1'b1; tick = 1'b0; en = '0; fccw = '0; pha = '0;
        amp = {4{AMP_ONE}};
        do_reset();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_valid", ch_valid, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_data", ch_data, 0);
        chk("rst_addr", rom_if.rom_addr, 0);

        // 1: single channel stepping through addresses 1, 2, 3
        en = 4'b0001; fccw[0] = 30'd1 << 19;
        frame("t1a", {11'd0, 11'd0, 11'd0, 11'd1});
        repeat (4) cyc();
        frame("t1b", {11'd0, 11'd0, 11'd0, 11'd2});
        repeat (4) cyc();
        frame("t1c", {11'd0, 11'd0, 11'd0, 11'd3});
        repeat (4) cyc();

        // 2: ch1 is ch0 shifted a quarter cycle
        do_reset();
        en = 4'b0011; fccw[0] = 30'd1 << 19; fccw[1] = 30'd1 << 19; pha[1] = 30'd1 << 28;
        frame("t2", {11'd0, 11'd0, 11'd513, 11'd1});
        repeat (3) cyc();

        // 3: negative step wraps down from 2047, back-to-back frames
        do_reset();
        en = 4'b0001; fccw = '0; pha = '0; fccw[0] = (30'd1 << 30) - (30'd1 << 19);
        frame("t3a", {11'd0, 11'd0, 11'd0, 11'd2047});
        frame("t3b", {11'd0, 11'd0, 11'd0, 11'd2046});
        chk("t3_no_overrun", overrun, 0);
        do_reset();
        fccw[0] = 30'd1536 << 19; pha[0] = 30'd1 << 29;
        frame("t3c", {11'd0, 11'd0, 11'd0, 11'd512});
        pha = '0;

        // 4: tick while busy is dropped and latched as overrun
        do_reset();
        en = 4'b0001; fccw[0] = 30'd1 << 19;
        fd = 0;
        tick = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c == 1) tick = 1'b0;
            if (c == 2) chk("t4_ovr_before", overrun, 0);
            if (c == 3) tick = 1'b1;
            if (c == 4) begin
                tick = 1'b0;
                chk("t4_ovr_set", overrun, 1);
            end
            if (frame_done === 1'b1) fd++;
        end
        chk("t4_one_done", fd, 1);
        frame("t4next", {11'd0, 11'd0, 11'd0, 11'd2});
        chk("t4_ovr_sticky", overrun, 1);
        do_reset();
        chk("t4_ovr_cleared", overrun, 0);

        // 5: reset mid-frame aborts and restarts accumulators
        en = 4'b0011; fccw[0] = 30'd1 << 19; fccw[1] = 30'd1 << 19;
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc(); cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_data", ch_data, 0);
        chk("t5_valid", ch_valid, 0);
        chk("t5_addr", rom_if.rom_addr, 0);
        for (int c = 0; c < 8; c++) begin
            cyc();
            chk($sformatf("t5_quiet_vld%0d", c), ch_valid, 0);
            chk($sformatf("t5_quiet_done%0d", c), frame_done, 0);
        end
        en = 4'b0001; fccw[1] = '0; fccw[0] = 30'd5 << 19;
        frame("t5next", {11'd0, 11'd0, 11'd0, 11'd5});

`ifdef DDFS_AMP_SCALE_EN
        // 6: gain of 0.5 on full-scale, extra latency, overrun at T+6
        do_reset();
        amp[0] = 16'd16384; en = 4'b0001; fccw = '0; fccw[0] = 30'd512 << 19;
        tick = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 1) tick = 1'b0;
            if (c == 4) begin
                chk("t6_vld", ch_valid, 4'b0001);
                chk("t6_half", ch_data[0], 16'd16383);
            end
            if (c == 6) begin
                chk("t6_done_early", frame_done, 0);
                chk("t6_busy6", busy, 1);
                tick = 1'b1;
            end
            if (c == 7) begin
                tick = 1'b0;
                chk("t6_done", frame_done, 1);
                chk("t6_ovr", overrun, 1);
            end
            if (c == 8) chk("t6_idle", busy, 0);
        end
        do_reset();
        amp[0] = 16'hFFFF; fccw[0] = 30'd1536 << 19;
        tick = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 1) tick = 1'b0;
            if (c == 4) chk("t6_sat_neg", ch_data[0], 16'h8000);
        end
        amp = {4{AMP_ONE}};
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
